// File: rtl/beagleg_pkg.sv
// rtl/beagleg_pkg.sv - shared command/state encodings and default record geometry
package beagleg_pkg;

    typedef enum logic [7:0] {
        CMD_NO_OP      = 8'h00,
        CMD_STATUS     = 8'h01,
        CMD_WRITE_FIFO = 8'h02
    } command_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STATUS,
        ST_RECEIVE,
        ST_COMMIT,
        ST_DISCARD
    } state_e;

    localparam int RECORD_WORDS = 4;
    localparam int DEPTH        = 16;

endpackage

// File: rtl/record_stager.sv
// rtl/record_stager.sv - holds one record of bytes and drains it as a back-to-back burst
module record_stager #(
    parameter int WordSize    = 8,
    parameter int RecordWords = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WordSize-1:0] load_word,
    input  logic                load_valid,
    input  logic                load_clear,
    input  logic                start_drain,
    output logic [WordSize-1:0] drain_data,
    output logic                drain_valid,
    output logic                drain_done
);

    localparam int IW = (RecordWords > 1) ? $clog2(RecordWords) : 1;

    logic [WordSize-1:0] stage [RecordWords];
    logic [IW-1:0]       wr_idx;
    logic [IW-1:0]       rd_idx;

    // write index wraps naturally after a full record, so a dropped record needs no clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            drain_valid <= 1'b0;
            for (int i = 0; i < RecordWords; i++) stage[i] <= '0;
        end else begin
            if (load_clear) begin
                wr_idx <= '0;
            end else if (load_valid) begin
                stage[wr_idx] <= load_word;
                wr_idx        <= wr_idx + IW'(1);
            end
            if (start_drain) begin
                drain_valid <= 1'b1;
                rd_idx      <= '0;
            end else if (drain_done) begin
                drain_valid <= 1'b0;
                rd_idx      <= '0;
            end else if (drain_valid) begin
                rd_idx <= rd_idx + IW'(1);
            end
        end
    end

    assign drain_done = drain_valid && (rd_idx == IW'(RecordWords - 1));
    assign drain_data = drain_valid ? stage[rd_idx] : '0;

endmodule

// File: rtl/spi_command_controller.sv
// rtl/spi_command_controller.sv - SPI command sequencer feeding whole records to the segment FIFO
// Optional drop/overflow statistics in the status byte: SPI_CMD_DROP_STATS_EN
module spi_command_controller
    import beagleg_pkg::*;
#(
    parameter int WordSize    = 8,
    parameter int RecordWords = RECORD_WORDS,
    parameter int Depth       = DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cs,
    input  logic [WordSize-1:0]                   rx_word,
    input  logic                                  rx_valid,
    output logic [WordSize-1:0]                   tx_word,
    input  logic [$clog2(Depth*RecordWords):0]    fifo_size,
    output logic                                  fifo_write_en,
    output logic [WordSize-1:0]                   fifo_data,
    output logic                                  busy
);

    localparam int RwLog = $clog2(RecordWords);
    localparam int CW    = (RecordWords > 1) ? RwLog : 1;

    state_e              state, state_next;
    logic [CW-1:0]       byte_cnt, cnt_next;
    logic                cs_pending;
    logic [7:0]          empty_slots;
    logic [WordSize-1:0] status_byte;
    logic                load_valid, load_clear, start_drain;
    logic                drop, viol, stats_clear;
    logic                drain_valid, drain_done;
    logic [WordSize-1:0] drain_data;

    assign empty_slots = 8'(Depth) - 8'(fifo_size >> RwLog);

    record_stager #(
        .WordSize    (WordSize),
        .RecordWords (RecordWords)
    ) u_stager (
        .clk         (clk),
        .reset       (reset),
        .load_word   (rx_word),
        .load_valid  (load_valid),
        .load_clear  (load_clear),
        .start_drain (start_drain),
        .drain_data  (drain_data),
        .drain_valid (drain_valid),
        .drain_done  (drain_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_cnt   <= '0;
            cs_pending <= 1'b0;
        end else begin
            state      <= state_next;
            byte_cnt   <= cnt_next;
            cs_pending <= (state == ST_COMMIT) && (state_next == ST_COMMIT) && (cs || cs_pending);
        end
    end

    // a commit burst always runs to completion; cs and stray bytes are only noted
    always_comb begin
        state_next  = state;
        cnt_next    = byte_cnt;
        load_valid  = 1'b0;
        load_clear  = 1'b0;
        start_drain = 1'b0;
        drop        = 1'b0;
        stats_clear = 1'b0;
        viol        = 1'b0;
        if (state == ST_COMMIT) begin
            viol = rx_valid && !cs;
            if (drain_done) begin
                state_next = (cs || cs_pending) ? ST_IDLE : ST_RECEIVE;
                cnt_next   = '0;
            end
        end else if (cs) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            load_clear = 1'b1;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    if (rx_word == WordSize'(CMD_STATUS)) begin
                        state_next = ST_STATUS;
                    end else if (rx_word == WordSize'(CMD_WRITE_FIFO)) begin
                        state_next = ST_RECEIVE;
                        cnt_next   = '0;
                        load_clear = 1'b1;
                    end
                end
                ST_STATUS: begin
                    state_next  = ST_DISCARD;
                    stats_clear = 1'b1;
                end
                ST_RECEIVE: begin
                    load_valid = 1'b1;
                    if (byte_cnt == CW'(RecordWords - 1)) begin
                        cnt_next = '0;
                        if (empty_slots != 8'd0) begin
                            start_drain = 1'b1;
                            state_next  = ST_COMMIT;
                        end else begin
                            drop = 1'b1;
                        end
                    end else begin
                        cnt_next = byte_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_CMD_DROP_STATS_EN
    logic       overflow;
    logic [6:0] dropped_cnt;
    logic [6:0] cnt_base;

    assign cnt_base = stats_clear ? 7'd0 : dropped_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow    <= 1'b0;
            dropped_cnt <= 7'd0;
        end else begin
            overflow    <= (overflow && !stats_clear) || viol;
            dropped_cnt <= (drop && cnt_base != 7'd127) ? cnt_base + 7'd1 : cnt_base;
        end
    end

    assign status_byte = WordSize'({overflow, dropped_cnt});
`else
    logic unused_stats;
    assign unused_stats = ^{drop, viol, stats_clear};
    assign status_byte  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_word <= '0;
        end else begin
            case (state)
                ST_IDLE:   tx_word <= WordSize'(empty_slots);
                ST_STATUS: tx_word <= status_byte;
                default:   tx_word <= '0;
            endcase
        end
    end

    assign fifo_write_en = drain_valid;
    assign fifo_data     = drain_data;
    assign busy          = (state == ST_COMMIT);

endmodule
